// File: rtl/ascon_inv_diffusion.sv
// Inverse of the Ascon linear diffusion layer, computed iteratively.
// Each lane map L = I ^ R^a ^ R^b has order 64, so L^-1 = L^63, which is the
// product of L^(2^k) for k = 0..5. L^(2^k) uses rotations (r * 2^k) mod 64.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start_i, ready_o=1
// RUN   | applying STEPS_PER_CYCLE squaring steps per clock, ready_o=0
// DONE  | result in state_o, done_o pulse, ready_o=1, may restart
module ascon_inv_diffusion #(
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             start_i,
    input  logic [4:0][63:0] state_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [4:0][63:0] state_o
);

    localparam int NB_STEP = 6;

    generate
        if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 ||
              STEPS_PER_CYCLE == 3 || STEPS_PER_CYCLE == 6)) begin : g_bad_steps
            $error("ascon_inv_diffusion: STEPS_PER_CYCLE must be 1, 2, 3 or 6");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t             fsm_q;
    logic [2:0]       k_q;
    logic [2:0]       k_next;
    logic [4:0][63:0] acc_q;
    logic [4:0][63:0] acc_next;

    // Rotation by zero falls out naturally: a 64-bit left shift by 64 is zero.
    function automatic logic [63:0] rotr(input logic [63:0] x, input logic [5:0] n);
        return (x >> n) | (x << (7'd64 - {1'b0, n}));
    endfunction

    function automatic logic [5:0] base_a(input int lane);
        case (lane)
            0:       return 6'd19;
            1:       return 6'd61;
            2:       return 6'd1;
            3:       return 6'd10;
            4:       return 6'd7;
            default: return 6'd0;
        endcase
    endfunction

    function automatic logic [5:0] base_b(input int lane);
        case (lane)
            0:       return 6'd28;
            1:       return 6'd39;
            2:       return 6'd6;
            3:       return 6'd17;
            4:       return 6'd41;
            default: return 6'd0;
        endcase
    endfunction

    // Chain of squaring steps k .. k+STEPS_PER_CYCLE-1 on every lane.
    always_comb begin
        logic [2:0]  kk;
        logic [63:0] x;
        kk       = '0;
        x        = '0;
        acc_next = acc_q;
        for (int j = 0; j < STEPS_PER_CYCLE; j++) begin
            kk = k_q + 3'(j);
            for (int l = 0; l < 5; l++) begin
                x           = acc_next[l];
                // (r << kk) in 6 bits is r * 2^kk mod 64
                acc_next[l] = x ^ rotr(x, base_a(l) << kk) ^ rotr(x, base_b(l) << kk);
            end
        end
        k_next = k_q + 3'(STEPS_PER_CYCLE);
    end

    // Sequencer with registered handshake outputs.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q   <= IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            state_o <= '0;
            done_o  <= 1'b0;
            ready_o <= 1'b1;
        end else begin
            case (fsm_q)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        acc_q   <= state_i;
                        k_q     <= '0;
                        ready_o <= 1'b0;
                        fsm_q   <= RUN;
                    end else begin
                        ready_o <= 1'b1;
                    end
                end
                RUN: begin
                    acc_q <= acc_next;
                    k_q   <= k_next;
                    if (k_next == 3'(NB_STEP)) begin
                        state_o <= acc_next;
                        done_o  <= 1'b1;
                        ready_o <= 1'b1;
                        fsm_q   <= DONE;
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        acc_q   <= state_i;
                        k_q     <= '0;
                        ready_o <= 1'b0;
                        fsm_q   <= RUN;
                    end else begin
                        ready_o <= 1'b1;
                        fsm_q   <= IDLE;
                    end
                end
                default: begin
                    done_o  <= 1'b0;
                    ready_o <= 1'b1;
                    k_q     <= '0;
                    fsm_q   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_inv_diffusion.sv
// Bench for ascon_inv_diffusion: four instances (1, 2, 3, 6 steps per cycle)
// checked by round trip against a forward Ascon diffusion model.
module tb_ascon_inv_diffusion;

    typedef logic [4:0][63:0] state_t;

    logic   clock_i = 1'b0;
    logic   resetb_i = 1'b0;
    logic   start    [4];
    state_t st_in    [4];
    logic   ready    [4];
    logic   done     [4];
    state_t st_out   [4];

    int spc [4] = '{1, 2, 3, 6};
    int ra  [5] = '{19, 61, 1, 10, 7};
    int rb  [5] = '{28, 39, 6, 17, 41};

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock_i = ~clock_i;

    ascon_inv_diffusion #(.STEPS_PER_CYCLE(1)) u_dut0 (
        .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start[0]), .state_i(st_in[0]),
        .ready_o(ready[0]), .done_o(done[0]), .state_o(st_out[0]));
    ascon_inv_diffusion #(.STEPS_PER_CYCLE(2)) u_dut1 (
        .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start[1]), .state_i(st_in[1]),
        .ready_o(ready[1]), .done_o(done[1]), .state_o(st_out[1]));
    ascon_inv_diffusion #(.STEPS_PER_CYCLE(3)) u_dut2 (
        .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start[2]), .state_i(st_in[2]),
        .ready_o(ready[2]), .done_o(done[2]), .state_o(st_out[2]));
    ascon_inv_diffusion #(.STEPS_PER_CYCLE(6)) u_dut3 (
        .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start[3]), .state_i(st_in[3]),
        .ready_o(ready[3]), .done_o(done[3]), .state_o(st_out[3]));

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        int m;
        m = n % 64;
        if (m == 0) return x;
        return (x >> m) | (x << (64 - m));
    endfunction

    // Forward Ascon linear layer.
    function automatic state_t diffuse(input state_t x);
        state_t y;
        for (int l = 0; l < 5; l++)
            y[l] = x[l] ^ rotr64(x[l], ra[l]) ^ rotr64(x[l], rb[l]);
        return y;
    endfunction

    function automatic state_t rand_state();
        state_t s;
        for (int l = 0; l < 5; l++) s[l] = {$urandom, $urandom};
        return s;
    endfunction

    // Start one computation on instance idx and check latency, handshake and result.
    task automatic run_one(input int idx, input state_t x_in, input state_t exp, input string tag);
        int  cyc;
        bit  got_done;
        bit  saw_ready;
        @(negedge clock_i);
        check({tag, " ready_idle"}, 320'(ready[idx]), 320'd1);
        start[idx] = 1'b1;
        st_in[idx] = x_in;
        @(posedge clock_i);
        #1;
        start[idx] = 1'b0;
        st_in[idx] = rand_state();
        cyc = 0;
        got_done = 1'b0;
        saw_ready = 1'b0;
        while (!got_done && cyc < 20) begin
            @(negedge clock_i);
            cyc++;
            if (done[idx]) got_done = 1'b1;
            else if (ready[idx]) saw_ready = 1'b1;
        end
        check({tag, " done_seen"}, 320'(got_done), 320'd1);
        check({tag, " latency"}, 320'(cyc - 1), 320'(6 / spc[idx]));
        check({tag, " ready_run"}, 320'(saw_ready), 320'd0);
        check({tag, " result"}, st_out[idx], exp);
        @(negedge clock_i);
        check({tag, " done_pulse"}, 320'(done[idx]), 320'd0);
        check({tag, " result_hold"}, st_out[idx], exp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        state_t x_vec, a_vec, b_vec, ones;
        int     cyc;
        bit     got_done;

        for (int i = 0; i < 4; i++) begin
            start[i] = 1'b0;
            st_in[i] = '0;
        end
        ones = '1;

        #12;
        check("reset state_o", st_out[0], '0);
        check("reset ready", 320'(ready[0]), 320'd1);
        check("reset done", 320'(done[0]), 320'd0);
        @(negedge clock_i);
        resetb_i = 1'b1;
        repeat (2) @(negedge clock_i);

        run_one(0, '0, '0, "zero");
        run_one(0, ones, ones, "ones");

        x_vec[0] = 64'h0123456789ABCDEF;
        x_vec[1] = 64'hFEDCBA9876543210;
        x_vec[2] = 64'h0F0F0F0F0F0F0F0F;
        x_vec[3] = 64'h8000000000000001;
        x_vec[4] = 64'hDEADBEEFCAFEBABE;
        for (int i = 0; i < 4; i++) begin
            run_one(i, diffuse(x_vec), x_vec, $sformatf("fixed_s%0d", spc[i]));
            run_one(i, '0, '0, $sformatf("zero_s%0d", spc[i]));
            run_one(i, ones, ones, $sformatf("ones_s%0d", spc[i]));
        end

        for (int n = 0; n < 1000; n++) begin
            x_vec = rand_state();
            run_one(0, diffuse(x_vec), x_vec, "rand_s1");
        end
        for (int i = 1; i < 4; i++) begin
            for (int n = 0; n < 50; n++) begin
                x_vec = rand_state();
                run_one(i, diffuse(x_vec), x_vec, $sformatf("rand_s%0d", spc[i]));
            end
        end

        // back-to-back restart in the DONE cycle, plus a start pulse during RUN
        a_vec = rand_state();
        b_vec = rand_state();
        @(negedge clock_i);
        start[0] = 1'b1;
        st_in[0] = diffuse(a_vec);
        @(posedge clock_i);
        #1;
        start[0] = 1'b0;
        cyc = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 20) begin
            @(negedge clock_i);
            cyc++;
            if (done[0]) got_done = 1'b1;
        end
        check("b2b first done", 320'(got_done), 320'd1);
        check("b2b first result", st_out[0], a_vec);
        check("b2b ready in done", 320'(ready[0]), 320'd1);
        start[0] = 1'b1;
        st_in[0] = diffuse(b_vec);
        @(posedge clock_i);
        #1;
        start[0] = 1'b0;
        st_in[0] = rand_state();
        cyc = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 20) begin
            @(negedge clock_i);
            cyc++;
            if (cyc == 2) begin
                start[0] = 1'b1;
                st_in[0] = rand_state();
            end
            if (cyc == 3) begin
                start[0] = 1'b0;
                check("b2b ready in run", 320'(ready[0]), 320'd0);
                check("b2b old result held", st_out[0], a_vec);
            end
            if (done[0]) got_done = 1'b1;
        end
        check("b2b second done", 320'(got_done), 320'd1);
        check("b2b second latency", 320'(cyc - 1), 320'd6);
        check("b2b second result", st_out[0], b_vec);
        @(negedge clock_i);
        check("b2b back to idle", 320'(ready[0]), 320'd1);

        // reset in the middle of RUN
        x_vec = rand_state();
        @(negedge clock_i);
        start[0] = 1'b1;
        st_in[0] = diffuse(x_vec);
        @(posedge clock_i);
        #1;
        start[0] = 1'b0;
        repeat (3) @(negedge clock_i);
        #2;
        resetb_i = 1'b0;
        #1;
        check("rst state_o", st_out[0], '0);
        check("rst ready", 320'(ready[0]), 320'd1);
        check("rst done", 320'(done[0]), 320'd0);
        repeat (2) @(negedge clock_i);
        resetb_i = 1'b1;
        got_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock_i);
            if (done[0]) got_done = 1'b1;
        end
        check("rst no done", 320'(got_done), 320'd0);
        check("rst out stays zero", st_out[0], '0);
        x_vec = rand_state();
        run_one(0, diffuse(x_vec), x_vec, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ascon_inv_diffusion.md
Name: ascon_inv_diffusion

Overview:
- Sequential inverse of the Ascon linear diffusion layer, applied lane-wise to the 320-bit state (type_state, 5 x 64-bit lanes).
- Used by the verification/analysis path to undo a diffusion step, e.g. to recover the S-box output from a captured state or to self-check the permutation datapath.
- Over GF(2)[x]/(x^64+1), each lane map L = I ^ R^a ^ R^b satisfies L^64 = I. Therefore L^-1 = L^63, which is the product of L^(2^k) for k = 0..5.
- L^(2^k) = I ^ R^(a*2^k mod 64) ^ R^(b*2^k mod 64). The block iterates these 6 steps.

Parameters:
- STEPS_PER_CYCLE, 1: number of the 6 squaring steps applied per clock. Legal values are 1, 2, 3, 6; any other value fails elaboration.
- NB_STEP, 6: total squaring steps. Localparam, fixed to 6.

Ports:
- clock_i  in  1  system clock, rising edge.
- resetb_i  in  1  asynchronous active-low reset.
- start_i  in  1  request; state_i is captured when start_i=1 and ready_o=1.
- state_i  in  type_state (5x64)  diffused state to invert.
- ready_o  out  1  block idle or in DONE, so a start is accepted.
- done_o  out  1  one-cycle pulse; state_o is valid from this cycle on.
- state_o  out  type_state (5x64)  inverse-diffused state. Held until the next accepted start.

Behaviour:
- Reset (resetb_i=0, asynchronous): FSM=IDLE, step counter k=0, accumulator=0, state_o=0, done_o=0, ready_o=1.
- All rotations are rotate-right by (r*2^k) mod 64, where r is the lane's base amount:
  - lane0: 19, 28
  - lane1: 61, 39
  - lane2: 1, 6
  - lane3: 10, 17
  - lane4: 7, 41
- One step: acc_lane <= acc_lane ^ rotr(acc_lane, ra_k) ^ rotr(acc_lane, rb_k).
- FSM states:
  - IDLE: ready_o=1. On start_i, latch state_i into acc, set k=0, go to RUN.
  - RUN: ready_o=0. Each cycle apply steps k .. k+STEPS_PER_CYCLE-1 combinationally in sequence, then k += STEPS_PER_CYCLE. When the new k = 6, copy the result to state_o and go to DONE.
  - DONE: done_o=1 for exactly this cycle, ready_o=1. If start_i=1, latch a new state_i, set k=0, go to RUN (back-to-back, no bubble). Otherwise go to IDLE.
- Latency: accepted start at edge N -> done_o=1 during the cycle after edge N + 6/STEPS_PER_CYCLE. With the default (1 step per cycle), done_o is asserted 6 cycles after acceptance.
- Throughput is one result per 6/STEPS_PER_CYCLE cycles.
- start_i during RUN: ignored; no latch, no effect on the computation.
- state_i is sampled only at acceptance. Changes to it afterwards have no effect.
- state_o updates only on the RUN->DONE transition. It holds its value in IDLE and RUN, so the previous result stays visible during a new computation.
- Lanes are independent. No carries and no cross-lane mixing.
- Reset asserted mid-RUN: immediate return to reset values; no done_o pulse.
- k is a 3-bit counter and never exceeds 6.

Test Plan:
- All-zero state_i, start -> done_o pulse exactly 6 cycles after acceptance; state_o = 0 in every lane; ready_o=0 during the 6 RUN cycles.
- All-ones state_i (0xFFFFFFFFFFFFFFFF per lane; L(ones)=ones) -> state_o = all-ones in every lane.
- Round trip with X = {0x0123456789ABCDEF, 0xFEDCBA9876543210, 0x0F0F0F0F0F0F0F0F, 0x8000000000000001, 0xDEADBEEFCAFEBABE}: drive state_i = diffusion(X) from the forward golden model -> state_o = X. Repeat with 1000 random X.
- Back-to-back: assert start_i in the DONE cycle with a new vector -> second done_o 6 cycles later, no idle bubble, both results correct. start_i pulsed during RUN is ignored and the result is unchanged.
- Reset: drop resetb_i at RUN cycle 3 -> outputs go to 0 and ready_o to 1 asynchronously, with no done_o. A new start after release computes correctly.
- Repeat the round-trip scenario with STEPS_PER_CYCLE = 2, 3 and 6 -> done_o latency of 3, 2 and 1 cycles respectively, with identical results.
